// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe register pipeline.
// Imported by the stage and top modules.
package dff_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3;

  function automatic int occ_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One valid/data register pair of the pipeline with its ready term.
// Data only loads on a real transfer; vacating a stage keeps stale data.
module dff_pipe_stage
  import dff_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  assign ready = down_ready | ~valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Multi-stage valid/ready register pipeline with flush and occupancy.
// Owns the stage chain, the occupancy counter and the complemented output.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [WIDTH-1:0]          out_data_b,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);

  localparam int OW = occ_w(DEPTH);

  logic push;
  logic pop;

  // Per-stage signals live in each generate scope so the ready
  // chain is a set of distinct nets rather than one looped vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             dn_rdy;
    logic             v;
    logic [WIDTH-1:0] d;
    logic             rdy;

    if (i == 0) begin : g_head
      assign up_v = push;
      assign up_d = in_data;
    end else begin : g_body
      assign up_v = g_stage[i-1].v;
      assign up_d = g_stage[i-1].d;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign dn_rdy = out_ready;
    end else begin : g_link
      assign dn_rdy = g_stage[i+1].rdy;
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .up_valid   (up_v),
      .up_data    (up_d),
      .down_ready (dn_rdy),
      .valid      (v),
      .data       (d),
      .ready      (rdy)
    );
  end

  assign in_ready   = g_stage[0].rdy & ~flush;
  assign out_valid  = g_stage[DEPTH-1].v;
  assign out_data   = g_stage[DEPTH-1].d;
  assign out_data_b = ~out_data;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OW'(push) - OW'(pop);
    end
  end

endmodule
